// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - request/response port and APB3 bus bundle for apb_master
interface apb_master_if #(
  parameter int NSLV = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic [NSLV-1:0]      PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [31:0]          PADDR;
  logic [31:0]          PWDATA;
  logic [32*NSLV-1:0]   PRDATA;
  logic [NSLV-1:0]      PREADY;

  // View of the APB initiator itself
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  // View of the requester plus the APB slaves around it
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready request to APB3 initiator with address decode and timeout
module apb_master #(
  parameter int SLV_BITS = 2,
  parameter int DEC_LSB  = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  apb_master_if.master bus
);
  localparam int          NSLV = 2 ** SLV_BITS;
  localparam logic [15:0] TO   = TIMEOUT[15:0];

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [SLV_BITS-1:0] sel_q, sel_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                sel_ready;
  logic                timeout_hit;
  logic [31:0]         sel_rdata;

  // Only the addressed slave's ready and data matter; completion beats timeout
  assign sel_ready   = bus.PREADY[sel_q];
  assign sel_rdata   = bus.PRDATA[32*int'(sel_q) +: 32];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO) && !sel_ready;

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> SETUP -> ACCESS -> IDLE, never chaining transfers
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.req_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (sel_ready || timeout_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Phase-dependent outputs; ready is withheld while reset is asserted
  always_comb begin
    bus.req_ready = 1'b0;
    bus.PSEL      = '0;
    bus.PENABLE   = 1'b0;
    case (state_q)
      S_IDLE:   bus.req_ready = !PRESET;
      S_SETUP:  bus.PSEL = NSLV'(1) << sel_q;
      S_ACCESS: begin
        bus.PSEL    = NSLV'(1) << sel_q;
        bus.PENABLE = 1'b1;
      end
      default:  ;
    endcase
  end

  // Datapath next state: latch request, count wait states, build the response
  always_comb begin
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (state_q == S_IDLE && bus.req_valid) begin
      write_d = bus.req_write;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      sel_d   = bus.req_addr[DEC_LSB +: SLV_BITS];
      cnt_d   = 16'h0000;
    end
    if (state_q == S_ACCESS) begin
      if (sel_ready) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = write_q ? 32'h0000_0000 : sel_rdata;
        rsp_err_d   = 1'b0;
      end else if (timeout_hit) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'hDEAD_BEEF;
        rsp_err_d   = 1'b1;
      end else if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'h0001;
      end
    end
  end

  // Datapath registers; reset drops any in-flight transfer without a response
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.PWRITE    = write_q;
  assign bus.PADDR     = addr_q;
  assign bus.PWDATA    = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master against a transaction-level model
module tb_apb_master;
  localparam int TO = 4;

  logic clk;
  logic rst;

  apb_master_if #(.NSLV(4)) bus ();

  apb_master #(.SLV_BITS(2), .DEC_LSB(8), .TIMEOUT(TO)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;
  int cyc     = 0;

  // Model: one outstanding transfer described by its acceptance cycle
  bit          m_active;
  int          m_t;
  logic [1:0]  m_sel;
  logic        m_wr;
  logic [31:0] m_addr, m_wd;
  logic        m_rv;
  logic [31:0] m_rd;
  logic        m_err;
  bit          m_acc;
  bit          dut_acc;
  int          acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    int w;
    m_acc = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_wr = 1'b0; m_addr = '0; m_wd = '0; m_sel = '0;
      m_rv = 1'b0; m_rd = '0; m_err = 1'b0;
    end else begin
      m_rv = 1'b0;
      if (m_active) begin
        if (cyc >= m_t + 2) begin
          w = cyc - m_t - 2;
          if (bus.PREADY[m_sel]) begin
            m_rv = 1'b1; m_err = 1'b0; m_active = 1'b0;
            m_rd = m_wr ? 32'h0 : bus.PRDATA[32*int'(m_sel) +: 32];
          end else if (TO != 0 && w == TO) begin
            m_rv = 1'b1; m_err = 1'b1; m_active = 1'b0;
            m_rd = 32'hDEAD_BEEF;
          end
        end
      end else if (bus.req_valid) begin
        m_wr = bus.req_write; m_addr = bus.req_addr; m_wd = bus.req_wdata;
        m_sel = bus.req_addr[9:8];
        m_active = 1'b1; m_t = cyc; m_acc = 1'b1;
      end
    end
    cyc++;
  endtask

  // One clock: check combinational ready, advance model, check registered outputs
  task automatic step();
    #1;
    check("req_ready", bus.req_ready, !rst && !m_active);
    dut_acc = bus.req_ready && bus.req_valid;
    if (dut_acc) acc_q.push_back(cyc);
    model_update();
    @(posedge clk);
    @(negedge clk);
    check("PSEL", bus.PSEL, m_active ? (4'b0001 << m_sel) : 4'b0000);
    check("PENABLE", bus.PENABLE, m_active && (cyc >= m_t + 2));
    check("PWRITE", bus.PWRITE, m_wr);
    check("PADDR", bus.PADDR, m_addr);
    check("PWDATA", bus.PWDATA, m_wd);
    check("rsp_valid", bus.rsp_valid, m_rv);
    if (m_rv) begin
      check("rsp_rdata", bus.rsp_rdata, m_rd);
      check("rsp_err", bus.rsp_err, m_err);
    end
    if (bus.rsp_valid) n_rsp++;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = v; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
  endtask

  initial begin
    int k;
    int r0;
    rst = 1'b1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    bus.PREADY = 4'hF;
    bus.PRDATA = '0;
    m_active = 0; m_t = 0; m_sel = 0; m_wr = 0; m_addr = 0; m_wd = 0;
    m_rv = 0; m_rd = 0; m_err = 0; m_acc = 0; dut_acc = 0;
    @(negedge clk);
    step();
    step();
    check("reset PSEL", bus.PSEL, 4'h0);
    check("reset PADDR", bus.PADDR, 32'h0);
    check("reset rsp_valid", bus.rsp_valid, 1'b0);
    rst = 1'b0;
    step();

    // Zero-wait write to slave 1
    set_req(1'b1, 1'b1, 32'h0000_0110, 32'h1234_5678);
    step();
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    check("wr setup PSEL", bus.PSEL, 4'b0010);
    check("wr setup PENABLE", bus.PENABLE, 1'b0);
    step();
    check("wr access PENABLE", bus.PENABLE, 1'b1);
    step();
    check("wr rsp_valid", bus.rsp_valid, 1'b1);
    check("wr rsp_rdata", bus.rsp_rdata, 32'h0);
    check("wr rsp_err", bus.rsp_err, 1'b0);

    // Read slave 3 with two wait states; other PREADY bits high and ignored
    bus.PRDATA = {32'hCAFE_F00D, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    set_req(1'b1, 1'b0, 32'h0000_0300, 32'h5555_AAAA);
    step();
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    bus.PREADY = 4'h7;
    for (int i = 0; i < 3; i++) step();
    check("rd no early rsp", bus.rsp_valid, 1'b0);
    bus.PREADY = 4'hF;
    step();
    check("rd rsp_valid T+5", bus.rsp_valid, 1'b1);
    check("rd rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    check("rd PADDR held", bus.PADDR, 32'h0000_0300);

    // Timeout: PREADY[0] held low
    bus.PRDATA = {32'hCAFE_F00D, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0BAD_F00D};
    set_req(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    step();
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    bus.PREADY = 4'hE;
    for (int i = 0; i < 5; i++) step();
    check("to 5th access PENABLE", bus.PENABLE, 1'b1);
    step();
    check("to rsp_valid", bus.rsp_valid, 1'b1);
    check("to rsp_err", bus.rsp_err, 1'b1);
    check("to rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("to PSEL", bus.PSEL, 4'h0);

    // Ready rises in the 5th ACCESS cycle: completion wins
    set_req(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    step();
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    bus.PREADY = 4'hE;
    for (int i = 0; i < 5; i++) step();
    bus.PREADY = 4'hF;
    step();
    check("late rsp_valid", bus.rsp_valid, 1'b1);
    check("late rsp_err", bus.rsp_err, 1'b0);
    check("late rsp_rdata", bus.rsp_rdata, 32'h0BAD_F00D);

    // Four queued requests with req_valid held high
    step();
    acc_q.delete();
    r0 = n_rsp;
    k = 0;
    set_req(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0000);
    for (int i = 0; i < 16; i++) begin
      step();
      if (m_acc) begin
        k++;
        if (k < 4) set_req(1'b1, 1'b1, 32'h0000_0200 + k, k);
        else set_req(1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    check("queue accepts", acc_q.size(), 4);
    for (int i = 1; i < acc_q.size(); i++)
      check("queue spacing", acc_q[i] - acc_q[0], 3 * i);
    check("queue rsp count", n_rsp - r0, 4);

    // Reset during ACCESS with PREADY low
    set_req(1'b1, 1'b1, 32'h0000_0144, 32'h7777_0001);
    step();
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    bus.PREADY = 4'h0;
    step();
    step();
    rst = 1'b1;
    step();
    check("rst PSEL", bus.PSEL, 4'h0);
    check("rst PENABLE", bus.PENABLE, 1'b0);
    check("rst PWRITE", bus.PWRITE, 1'b0);
    check("rst PADDR", bus.PADDR, 32'h0);
    check("rst PWDATA", bus.PWDATA, 32'h0);
    check("rst rsp_valid", bus.rsp_valid, 1'b0);
    check("rst rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst rsp_err", bus.rsp_err, 1'b0);
    rst = 1'b0;
    bus.PREADY = 4'hF;
    #1;
    check("rst release req_ready", bus.req_ready, 1'b1);
    r0 = n_rsp;
    for (int i = 0; i < 8; i++) step();
    check("rst no rsp", n_rsp - r0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (!bus.req_valid || m_acc)
        set_req($urandom_range(0, 2) != 0, 1'($urandom), $urandom, $urandom);
      bus.PREADY = 4'($urandom);
      bus.PRDATA = {$urandom, $urandom, $urandom, $urandom};
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
